// File: rtl/elastic_pipe_register.sv
// elastic_pipe_register: DEPTH-stage valid/ready register chain with bubble
// collapsing, synchronous flush and a registered occupancy count.
module elastic_pipe_register #(
   parameter int WORD_LENGTH    = 34,
   parameter int DEPTH          = 3,
   parameter bit CLEAR_ON_FLUSH = 1'b0
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         flush,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [WORD_LENGTH-1:0]       in_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [WORD_LENGTH-1:0]       out_data,
   output logic [$clog2(DEPTH+1)-1:0]   occupancy
);
   localparam int OCC_W = $clog2(DEPTH+1);

   logic [WORD_LENGTH-1:0] stage_data [DEPTH];
   logic [WORD_LENGTH-1:0] data_up    [DEPTH];
   logic [DEPTH-1:0]       v;
   logic [DEPTH-1:0]       v_up;
   logic [DEPTH-1:0]       v_next;
   logic [DEPTH-1:0]       rdy;
   logic [OCC_W-1:0]       occ_next;
   logic                   in_xfer;

   // Ready ripples back from the consumer; an empty stage is always ready,
   // which is what lets bubbles collapse behind a stalled output.
   always_comb begin
      logic chain;
      chain = out_ready;
      rdy   = '0;
      for (int k = DEPTH-1; k >= 0; k--) begin
         chain  = !v[k] || chain;
         rdy[k] = chain;
      end
   end

   assign in_ready  = rdy[0] & ~flush;
   assign in_xfer   = in_valid & in_ready;
   assign out_valid = v[DEPTH-1] & ~flush;
   assign out_data  = stage_data[DEPTH-1];

   // What each stage would take from its upstream neighbour; stage 0 is fed
   // by the input port, and only on a real transfer so stray input data never enters.
   always_comb begin
      v_up[0]    = in_xfer;
      data_up[0] = in_data;
      for (int k = 1; k < DEPTH; k++) begin
         v_up[k]    = v[k-1];
         data_up[k] = stage_data[k-1];
      end
   end

   always_comb begin
      v_next   = v;
      occ_next = '0;
      for (int k = 0; k < DEPTH; k++) begin
         if (rdy[k]) begin
            v_next[k] = v_up[k];
         end
      end
      for (int k = 0; k < DEPTH; k++) begin
         occ_next = occ_next + OCC_W'(v_next[k]);
      end
   end

   // Data only moves with a valid word, so an empty output stage keeps
   // showing the last word it presented.
   always_ff @(posedge clk) begin
      if (reset) begin
         v         <= '0;
         occupancy <= '0;
         for (int k = 0; k < DEPTH; k++) begin
            stage_data[k] <= '0;
         end
      end else if (flush) begin
         v         <= '0;
         occupancy <= '0;
         if (CLEAR_ON_FLUSH) begin
            for (int k = 0; k < DEPTH; k++) begin
               stage_data[k] <= '0;
            end
         end
      end else begin
         v         <= v_next;
         occupancy <= occ_next;
         for (int k = 0; k < DEPTH; k++) begin
            if (rdy[k] && v_up[k]) begin
               stage_data[k] <= data_up[k];
            end
         end
      end
   end

endmodule
